// File: rtl/serial_parity_rx.sv
// serial_parity_rx: deserialises start/data/parity/stop frames and flags parity and framing errors
module serial_parity_rx #(
   parameter int DATA_W     = 8,
   parameter bit PARITY_ODD = 1'b0,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sin_valid,
   input  logic              sin,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy,
   output logic [CNT_W-1:0]  err_cnt
);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state, state_nx;
   logic [BW-1:0] bit_cnt;
   logic [DATA_W-1:0] sh;
   logic acc, perr;
   wire last = bit_cnt == BW'(DATA_W - 1);
   wire bad = perr | ~sin;
   assign busy = state != IDLE;
   always_comb begin
      state_nx = state;
      if (sin_valid)
         case (state)
            IDLE:   state_nx = sin ? IDLE : DATA;
            DATA:   state_nx = last ? PARITY : DATA;
            PARITY: state_nx = STOP;
            STOP:   state_nx = IDLE;
         endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // idle strobes re-arm the datapath, so a start bit always begins from a clean slate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt    <= '0;
         sh         <= '0;
         acc        <= 1'b0;
         perr       <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         err_cnt    <= '0;
      end else begin
         data_valid <= 1'b0;
         if (sin_valid)
            case (state)
               IDLE: begin
                  bit_cnt <= '0;
                  sh      <= '0;
                  acc     <= PARITY_ODD;
               end
               DATA: begin
                  sh      <= {sin, sh[DATA_W-1:1]};
                  acc     <= acc ^ sin;
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: perr <= acc ^ sin;
               STOP: begin
                  data_out   <= sh;
                  parity_err <= perr;
                  frame_err  <= ~sin;
                  data_valid <= 1'b1;
                  if (bad && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
               end
            endcase
      end
   end
endmodule
